// File: rtl/alien_fleet_pkg.sv
// Shared types and constants for the alien fleet sequencer.
// The LFSR seed, taps and step function are used only when FLEET_RANDOM_FIRE_EN is defined.
package alien_fleet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARCH_R,
    DROP_R,
    MARCH_L,
    DROP_L,
    CLEAR
  } fleet_state_e;

  localparam int          FLEET_N_ALIENS    = 8;
  localparam logic [8:0]  FLEET_BASE_SPEED  = 9'd60;
  localparam logic [8:0]  FLEET_SPEED_STEP  = 9'd6;
  localparam logic [8:0]  FLEET_MIN_SPEED   = 9'd4;
  localparam logic [11:0] FLEET_FIRE_PERIOD = 12'd120;
  localparam logic [7:0]  FLEET_CLEAR_HOLD  = 8'd90;

  // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/alien_fleet_ctrl_arbiter.sv
// Combinational round-robin search: first requester at or after start_i,
// wrapping at N, reported as a one-hot grant plus its index.
module fleet_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Walk from the farthest candidate back to start_i so the nearest hit wins.
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start_i) + k) % N;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Fleet sequencer: march/drop commands, speed from live count, fire
// scheduling and wave-clear handling. Define FLEET_RANDOM_FIRE_EN to draw
// the fire interval and search start from an LFSR instead of round-robin.
module alien_fleet_ctrl
  import alien_fleet_pkg::*;
#(
  parameter int          N_ALIENS    = FLEET_N_ALIENS,
  parameter logic [8:0]  BASE_SPEED  = FLEET_BASE_SPEED,
  parameter logic [8:0]  SPEED_STEP  = FLEET_SPEED_STEP,
  parameter logic [8:0]  MIN_SPEED   = FLEET_MIN_SPEED,
  parameter logic [11:0] FIRE_PERIOD = FLEET_FIRE_PERIOD,
  parameter logic [7:0]  CLEAR_HOLD  = FLEET_CLEAR_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [9:0]          xCoord,
  input  logic [9:0]          yCoord,
  input  logic [N_ALIENS-1:0] alien_edge,
  input  logic [N_ALIENS-1:0] alien_alive,
  output logic                move_left,
  output logic                move_right,
  output logic                move_down,
  output logic [8:0]          alienSpeed,
  output logic [N_ALIENS-1:0] fire_grant,
  output logic                alien_rst,
  output logic [3:0]          level
);

  localparam int IW = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;
  localparam int CW = $clog2(N_ALIENS + 1);

  fleet_state_e        state_q, state_d;
  logic [8:0]          step_cnt_q, step_cnt_d;
  logic [11:0]         fire_cnt_q, fire_cnt_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [N_ALIENS-1:0] fire_grant_q, fire_grant_d;
  logic [3:0]          level_q, level_d;
  logic [8:0]          speed_q, speed_d;
  logic                pix0, pix0_q, frame_tick_q, ignore_q;

  assign pix0 = (xCoord == 10'd0) && (yCoord == 10'd0);

  // One-clk frame tick on the rising edge of the scan origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix0_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix0_q       <= pix0;
      frame_tick_q <= pix0 & ~pix0_q;
    end
  end

  logic [CW-1:0] alive_cnt;

  // Population count of live aliens.
  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < N_ALIENS; i++) alive_cnt = alive_cnt + CW'(alien_alive[i]);
  end

  logic [15:0] dead_w, cut_w;
  logic [8:0]  speed_target;

  // Step period shrinks per dead alien; wide intermediate avoids underflow wrap.
  always_comb begin
    dead_w = 16'(N_ALIENS) - 16'(alive_cnt);
    cut_w  = 16'(SPEED_STEP) * dead_w;
    if (cut_w >= 16'(BASE_SPEED)) begin
      speed_target = MIN_SPEED;
    end else begin
      speed_target = BASE_SPEED - cut_w[8:0];
      if (speed_target < MIN_SPEED) speed_target = MIN_SPEED;
    end
  end

  logic [11:0]   fire_interval;
  logic [IW-1:0] search_start;

`ifdef FLEET_RANDOM_FIRE_EN
  logic [15:0] lfsr_q;

  // LFSR advances once per frame; menu mode reseeds it with the rest of the fleet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               lfsr_q <= LFSR_SEED;
    else if (!mode)        lfsr_q <= LFSR_SEED;
    else if (frame_tick_q) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign fire_interval = 12'(FIRE_PERIOD >> 1) + 12'(lfsr_q[11:6]);
  assign search_start  = IW'(32'(lfsr_q[2:0]) % N_ALIENS);
`else
  assign fire_interval = FIRE_PERIOD;
  assign search_start  = (rr_ptr_q == IW'(N_ALIENS - 1)) ? '0 : rr_ptr_q + IW'(1);
`endif

  logic [N_ALIENS-1:0] arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  fleet_rr_arbiter #(.N(N_ALIENS), .IW(IW)) u_arb (
    .req_i   (alien_alive),
    .start_i (search_start),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  logic clear_done, rst_pulse, alive_ignore, in_wave, wave_clear;

  // alien_alive is stale while the wave respawns, so it is masked for the
  // pulse cycle and the one after.
  assign clear_done   = (state_q == CLEAR) && frame_tick_q &&
                        (step_cnt_q == 9'(CLEAR_HOLD) - 9'd1);
  assign rst_pulse    = mode && !rst && ((state_q == IDLE) || clear_done);
  assign alive_ignore = rst_pulse | ignore_q;
  assign in_wave      = state_q inside {MARCH_R, DROP_R, MARCH_L, DROP_L};
  assign wave_clear   = in_wave && frame_tick_q && (alive_cnt == '0) && !alive_ignore;

  // Next-state, counters and command outputs.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    fire_cnt_d   = fire_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    fire_grant_d = '0;
    level_d      = level_q;
    speed_d      = speed_q;
    move_left    = 1'b0;
    move_right   = 1'b0;
    move_down    = 1'b0;
    alien_rst    = rst_pulse;

    case (state_q)
      MARCH_R:        move_right = 1'b1;
      MARCH_L:        move_left  = 1'b1;
      DROP_R, DROP_L: move_down  = 1'b1;
      default:        ;
    endcase

    if (frame_tick_q && !alive_ignore) speed_d = speed_target;

    case (state_q)
      IDLE: if (mode) state_d = MARCH_R;
      MARCH_R, MARCH_L: begin
        if (wave_clear) begin
          state_d    = CLEAR;
          step_cnt_d = '0;
        end else if (frame_tick_q && (|alien_edge)) begin
          state_d    = (state_q == MARCH_R) ? DROP_R : DROP_L;
          step_cnt_d = '0;
        end
      end
      DROP_R, DROP_L: begin
        if (wave_clear) begin
          state_d    = CLEAR;
          step_cnt_d = '0;
        end else if (frame_tick_q) begin
          // speed+1 ticks in total so every alien completes one drop step.
          if (step_cnt_q >= speed_q) state_d = (state_q == DROP_R) ? MARCH_L : MARCH_R;
          else                       step_cnt_d = step_cnt_q + 9'd1;
        end
      end
      CLEAR: begin
        if (clear_done) begin
          state_d    = MARCH_R;
          step_cnt_d = '0;
          level_d    = (level_q == 4'd15) ? level_q : level_q + 4'd1;
        end else if (frame_tick_q) begin
          step_cnt_d = step_cnt_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_wave && frame_tick_q && !wave_clear && !alive_ignore) begin
      if (fire_cnt_q >= fire_interval - 12'd1) begin
        fire_cnt_d = '0;
        if (arb_valid) begin
          fire_grant_d = arb_grant;
          rr_ptr_d     = arb_idx;
        end
      end else begin
        fire_cnt_d = fire_cnt_q + 12'd1;
      end
    end

    if (!mode) begin
      state_d      = IDLE;
      step_cnt_d   = '0;
      fire_cnt_d   = '0;
      rr_ptr_d     = IW'(N_ALIENS - 1);
      fire_grant_d = '0;
      level_d      = '0;
      speed_d      = BASE_SPEED;
    end
  end

  // Fleet state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      step_cnt_q   <= '0;
      fire_cnt_q   <= '0;
      rr_ptr_q     <= IW'(N_ALIENS - 1);
      fire_grant_q <= '0;
      level_q      <= '0;
      speed_q      <= BASE_SPEED;
      ignore_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      fire_cnt_q   <= fire_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      fire_grant_q <= fire_grant_d;
      level_q      <= level_d;
      speed_q      <= speed_d;
      ignore_q     <= rst_pulse;
    end
  end

  assign alienSpeed = speed_q;
  assign fire_grant = fire_grant_q;
  assign level      = level_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Self-checking bench for alien_fleet_ctrl with a frame-level reference model.
module tb_alien_fleet_ctrl;

  logic       clk = 1'b0;
  logic       rst, mode;
  logic [9:0] xCoord, yCoord;
  logic [7:0] alien_edge, alien_alive;
  logic       move_left, move_right, move_down;
  logic [8:0] alienSpeed;
  logic [7:0] fire_grant;
  logic       alien_rst;
  logic [3:0] level;

  always #5 clk = ~clk;

  alien_fleet_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .xCoord      (xCoord),
    .yCoord      (yCoord),
    .alien_edge  (alien_edge),
    .alien_alive (alien_alive),
    .move_left   (move_left),
    .move_right  (move_right),
    .move_down   (move_down),
    .alienSpeed  (alienSpeed),
    .fire_grant  (fire_grant),
    .alien_rst   (alien_rst),
    .level       (level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: game phase 0 menu, 1 marching, 2 dropping, 3 cleared.
  int         m_phase, m_drop_ticks, m_clear_ticks, m_fire_ticks, m_last, m_level, m_speed;
  bit         m_right, m_rst;
  logic [7:0] m_grant;
  logic       obs_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int speed_of(input logic [7:0] alive);
    int s;
    s = 60 - 6 * (8 - $countones(alive));
    return (s < 4) ? 4 : s;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_level = 0; m_speed = 60; m_fire_ticks = 0; m_last = 7;
    m_grant = '0; m_rst = 1'b0; m_right = 1'b1; m_drop_ticks = 0; m_clear_ticks = 0;
  endfunction

  function automatic void model_start();
    m_phase = 1; m_right = 1'b1; m_grant = '0;
  endfunction

  function automatic void model_tick(input logic [7:0] alive, input logic [7:0] edge_v);
    int  p, old_speed;
    bit  keep_speed;
    p = m_phase; old_speed = m_speed; keep_speed = 1'b0;
    m_grant = '0; m_rst = 1'b0;
    if (p == 1 || p == 2) begin
      if (alive == 8'h00) begin
        m_phase = 3; m_clear_ticks = 0;
      end else begin
        m_fire_ticks++;
        if (m_fire_ticks == 120) begin
          m_fire_ticks = 0;
          for (int k = 1; k <= 8; k++) begin
            int j;
            j = (m_last + k) % 8;
            if (alive[j]) begin m_grant[j] = 1'b1; m_last = j; break; end
          end
        end
        if (p == 1 && edge_v != 8'h00) begin
          m_phase = 2; m_drop_ticks = 0;
        end else if (p == 2) begin
          m_drop_ticks++;
          if (m_drop_ticks > old_speed) begin m_phase = 1; m_right = !m_right; end
        end
      end
    end else if (p == 3) begin
      m_clear_ticks++;
      if (m_clear_ticks == 90) begin
        m_level = (m_level < 15) ? m_level + 1 : 15;
        m_rst = 1'b1; m_phase = 1; m_right = 1'b1; keep_speed = 1'b1;
      end
    end
    if (!keep_speed) m_speed = speed_of(alive);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".move_right"}, 32'(move_right), 32'(m_phase == 1 && m_right));
    check({tag, ".move_left"},  32'(move_left),  32'(m_phase == 1 && !m_right));
    check({tag, ".move_down"},  32'(move_down),  32'(m_phase == 2));
    check({tag, ".speed"},      32'(alienSpeed), 32'(m_speed));
    check({tag, ".level"},      32'(level),      32'(m_level));
    check({tag, ".fire_grant"}, 32'(fire_grant), 32'(m_grant));
    check({tag, ".alien_rst"},  32'(alien_rst),  32'd0);
  endtask

  // One frame: origin for a clk, then the tick clk, then compare.
  task automatic frame(input logic [7:0] alive, input logic [7:0] edge_v);
    alien_alive = alive; alien_edge = edge_v; xCoord = '0; yCoord = '0;
    @(posedge clk); #1;
    xCoord = 10'd7;
    check("grant_pulse_width", 32'(fire_grant), 32'd0);
    obs_rst = alien_rst;
    @(posedge clk); #1;
    alien_edge = '0;
    model_tick(alive, edge_v);
    check("alien_rst_on_tick", 32'(obs_rst), 32'(m_rst));
    check_all("tick");
  endtask

  task automatic start_wave(input string tag);
    rst = 1'b0; mode = 1'b1; #1;
    check({tag, ".alien_rst_pulse"}, 32'(alien_rst), 32'd1);
    @(posedge clk); #1;
    model_start();
    check_all(tag);
  endtask

  int         drop_cnt, clear_frames, rst_seen;
  bit         fired;
  logic [7:0] got[$];
  logic [7:0] exp_g[3];
  logic [7:0] rnd_edge;

  initial begin
    rst = 1'b1; mode = 1'b0; xCoord = 10'd7; yCoord = '0;
    alien_edge = '0; alien_alive = 8'hFF; obs_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check_all("por");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("menu_idle");
    start_wave("power_up");

    // March right, then an edge from alien 7.
    repeat (4) frame(8'hFF, 8'h00);
    frame(8'hFF, 8'h80);
    drop_cnt = int'(move_down);
    for (int f = 0; f < 100 && move_down; f++) begin
      frame(8'hFF, 8'h00);
      if (move_down) drop_cnt++;
    end
    check("drop_len", 32'(drop_cnt), 32'd61);
    check("march_left_after_drop", 32'(move_left), 32'd1);

    // Asynchronous reset in the middle of MARCH_L.
    repeat (2) frame(8'hFF, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1; mode = 1'b1; #1;
    model_reset();
    check_all("rst_mid_march");
    @(posedge clk); #1;
    start_wave("rst_release");
    check("speed_after_rst", 32'(alienSpeed), 32'd60);

    // Speed follows the live count.
    frame(8'h0F, 8'h00);
    check("speed_0F", 32'(alienSpeed), 32'd36);
    frame(8'h01, 8'h00);
    check("speed_01", 32'(alienSpeed), 32'd18);

    // Fire scheduling: park the pointer on alien 2, then walk 0010_0101.
    fired = 1'b0;
    for (int f = 0; f < 200 && !fired; f++) begin
      frame(8'h04, 8'h00);
      if (fire_grant != 8'h00) fired = 1'b1;
    end
    check("first_grant", 32'(fire_grant), 32'h04);
    for (int f = 0; f < 400 && got.size() < 3; f++) begin
      frame(8'h25, 8'h00);
      if (fire_grant != 8'h00) got.push_back(fire_grant);
    end
    exp_g = '{8'h20, 8'h01, 8'h04};
    check("grant_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("grant_seq", (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(exp_g[i]));

    // Randomized marching with occasional edges.
    for (int f = 0; f < 300; f++) begin
      rnd_edge = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      frame(8'($urandom_range(1, 255)), rnd_edge);
    end

    // Wave clear on the same tick as an edge.
    for (int f = 0; f < 200 && m_phase != 1; f++) frame(8'hFF, 8'h00);
    frame(8'h00, 8'h80);
    check("clear_moves", 32'({move_left, move_right, move_down}), 32'd0);
    clear_frames = 0; rst_seen = 0;
    for (int f = 0; f < 120 && rst_seen == 0; f++) begin
      frame(8'h00, 8'h00);
      clear_frames++;
      if (obs_rst) rst_seen++;
    end
    check("clear_hold", 32'(clear_frames), 32'd90);
    check("level_after_clear", 32'(level), 32'd1);
    check("march_after_clear", 32'(move_right), 32'd1);
    frame(8'hFF, 8'h00);
    check("speed_new_wave", 32'(alienSpeed), 32'd60);

    // Menu mode during DROP_R.
    frame(8'hFF, 8'h01);
    check("drop_r_entered", 32'(move_down), 32'd1);
    repeat (3) frame(8'hFF, 8'h00);
    @(posedge clk); #1;
    mode = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_all("mode_low");
    check("mode_low_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    check("mode_low_no_rst", 32'(alien_rst), 32'd0);
    start_wave("mode_return");
    frame(8'hFF, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
